// File: rtl/mm_multitimer.sv
// Multi-channel RIOT-style interval timer: CH independent W-bit counters, each with
// a 1/8/64/1024 prescaler, one-shot or auto-reload mode, and a shared active-low IRQ.
module mm_multitimer #(
  parameter int CH = 2,
  parameter int W  = 8,
  parameter int AW = $clog2(CH) + 2
) (
  input  logic          CLK,
  input  logic          RES,
  input  logic          CS,
  input  logic          WE,
  input  logic [AW-1:0] A,
  input  logic [W-1:0]  D_IN,
  output logic [W-1:0]  D_OUT,
  output logic          IRQ_N,
  output logic [CH-1:0] EXPIRED
);

  typedef enum logic [1:0] {
    REG_COUNT  = 2'd0,
    REG_CTRL   = 2'd1,
    REG_STATUS = 2'd2,
    REG_RELOAD = 2'd3
  } reg_e;

  logic [AW-1:0]   chan;
  reg_e            rsel;
  logic            rd_en;
  logic [CH*W-1:0] rd_all;
  logic [CH-1:0]   irq_src;

  assign chan  = A >> 2;
  assign rsel  = reg_e'(A[1:0]);
  assign rd_en = CS & ~WE;

  for (genvar gi = 0; gi < CH; gi++) begin : g_ch
    logic [W-1:0] count;
    logic [W-1:0] reload;
    logic [W-1:0] rdata;
    logic [9:0]   pc;
    logic [9:0]   pc_top;
    logic [1:0]   ps;
    logic         ie, mode, run, flag, expd, pulse;
    logic         hit, wr_count, wr_ctrl, wr_status, wr_reload, rd_count;
    logic         tick, step_en, underflow;

    assign hit       = CS && (chan == AW'(gi));
    assign wr_count  = hit && WE && (rsel == REG_COUNT);
    assign wr_ctrl   = hit && WE && (rsel == REG_CTRL);
    assign wr_status = hit && WE && (rsel == REG_STATUS);
    assign wr_reload = hit && WE && (rsel == REG_RELOAD);
    assign rd_count  = hit && !WE && (rsel == REG_COUNT);

    always_comb begin
      pc_top = '0;
      case (ps)
        2'd0:    pc_top = 10'd0;
        2'd1:    pc_top = 10'd7;
        2'd2:    pc_top = 10'd63;
        default: pc_top = 10'd1023;
      endcase
    end

    // After a one-shot expiry the counter free-runs at the clock rate.
    assign tick      = run && (pc == '0);
    assign step_en   = run && (tick || expd);
    assign underflow = step_en && (count == '0);

    // Later assignments take priority: COUNT write beats underflow, underflow beats clears.
    always_ff @(posedge CLK or posedge RES) begin
      if (RES) begin
        count  <= '0;
        reload <= '0;
        pc     <= '0;
        ps     <= '0;
        ie     <= 1'b0;
        mode   <= 1'b0;
        run    <= 1'b0;
        flag   <= 1'b0;
        expd   <= 1'b0;
        pulse  <= 1'b0;
      end else begin
        pulse <= underflow;
        if (run) pc <= tick ? pc_top : pc - 10'd1;
        if ((wr_status && D_IN[0]) || (rd_count && !mode)) flag <= 1'b0;
        if (step_en) begin
          if (underflow) begin
            flag <= 1'b1;
            if (mode) begin
              count <= reload;
            end else begin
              count <= '1;
              expd  <= 1'b1;
            end
          end else begin
            count <= count - W'(1);
          end
        end
        if (wr_ctrl) begin
          ps   <= D_IN[1:0];
          ie   <= D_IN[2];
          mode <= D_IN[3];
          run  <= D_IN[4];
        end
        if (wr_reload) reload <= D_IN;
        if (wr_count) begin
          count  <= D_IN;
          reload <= D_IN;
          pc     <= pc_top;
          run    <= 1'b1;
          flag   <= 1'b0;
          expd   <= 1'b0;
          pulse  <= 1'b0;
        end
      end
    end

    always_comb begin
      rdata = '0;
      case (rsel)
        REG_COUNT:  rdata = count;
        REG_CTRL:   rdata = W'({run, mode, ie, ps});
        REG_STATUS: rdata = W'({expd, run, flag});
        REG_RELOAD: rdata = reload;
        default:    rdata = '0;
      endcase
    end

    assign rd_all[gi*W +: W] = (hit && rd_en) ? rdata : '0;
    assign irq_src[gi]       = flag & ie;
    assign EXPIRED[gi]       = pulse;
  end

  always_comb begin
    D_OUT = '0;
    for (int unsigned i = 0; i < CH; i++) D_OUT = D_OUT | rd_all[i*W +: W];
  end

  assign IRQ_N = ~|irq_src;

endmodule
